// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//
// Sends one command byte to a PS/2 keyboard using the host-request protocol and
// checks the device ACK. The shared open-drain pins are driven through
// output enables; busy tells the scancode receiver to ignore the bus.
//
// Handshake: a byte is taken on any cycle where tx_valid and tx_ready are both
// high; tx_ready is high only in IDLE, so tx_valid is ignored during a transfer.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   tx_data       command byte
//   tx_valid      command request
//   tx_ready      high only in IDLE
//   tx_done       one-cycle pulse: byte sent and ACKed
//   tx_err        one-cycle pulse: timeout or missing ACK
//   busy          high in every state except IDLE
//   ps2_clk_in    raw PS/2 clock pin level
//   ps2_data_in   raw PS/2 data pin level
//   ps2_clk_oe    1 = pull PS/2 clock low
//   ps2_data_oe   1 = pull PS/2 data low
//   fsm_state     current FSM state encoding (debug)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [3:0] fsm_state
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INHIBIT = 4'd1,
        REQ     = 4'd2,
        DATA    = 4'd3,
        PARITY  = 4'd4,
        STOP    = 4'd5,
        ACK     = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_t;

    state_t state, state_n;

    // Input conditioning
    logic             clk_s1, clk_s2, data_s1, data_s2;
    logic             clk_filt, clk_filt_d;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_s1     <= ps2_clk_in;
            clk_s2     <= clk_s1;
            data_s1    <= ps2_data_in;
            data_s2    <= data_s1;
            clk_filt_d <= clk_filt;
            // The filtered level only follows after FILTER_LEN consecutive
            // samples that disagree with it; any agreeing sample restarts.
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    // Transfer datapath registers
    logic [7:0]       shreg, shreg_n;
    logic             parity, parity_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic             data_oe, data_oe_n;
    logic [INH_W-1:0] inh_cnt, inh_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            parity  <= 1'b0;
            bitcnt  <= '0;
            data_oe <= 1'b0;
            inh_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            parity  <= parity_n;
            bitcnt  <= bitcnt_n;
            data_oe <= data_oe_n;
            inh_cnt <= inh_n;
            tmo_cnt <= tmo_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        parity_n  = parity;
        bitcnt_n  = bitcnt;
        data_oe_n = data_oe;
        inh_n     = inh_cnt;
        tmo_n     = tmo_cnt;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_n  = tx_data;
                    parity_n = ~^tx_data;
                    inh_n    = '0;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    // Start bit: data goes low as the clock is released.
                    data_oe_n = 1'b1;
                    tmo_n     = '0;
                    state_n   = REQ;
                end else begin
                    inh_n = inh_cnt + 1'b1;
                end
            end
            REQ: begin
                if (fall) begin
                    data_oe_n = ~shreg[0];
                    shreg_n   = {1'b0, shreg[7:1]};
                    bitcnt_n  = 4'd1;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    if (bitcnt < 4'd8) begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = {1'b0, shreg[7:1]};
                        bitcnt_n  = bitcnt + 1'b1;
                    end else begin
                        data_oe_n = ~parity;
                        state_n   = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    data_oe_n = 1'b0;
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = data_s2 ? ERR : ACK;
                end
            end
            ACK: begin
                if (clk_filt && data_s2) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Device-paced states share one watchdog that restarts on each fall.
        if ((state == REQ) || (state == DATA) || (state == PARITY) ||
            (state == STOP) || (state == ACK)) begin
            if (fall) begin
                tmo_n = '0;
            end else if (state_n == state) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n = ERR;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
        end

        // Lines are released whenever the transfer ends or aborts.
        if ((state_n == ERR) || (state_n == IDLE)) begin
            data_oe_n = 1'b0;
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign tx_done     = (state == DONE);
    assign tx_err      = (state == ERR);
    assign ps2_clk_oe  = (state == INHIBIT);
    assign ps2_data_oe = data_oe;
    assign fsm_state   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: device model on the open-drain pins, directed
// byte vectors with hand-computed line bits and parity.
module tb_ps2_host_tx;

    localparam int HALF = 50;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [3:0] fsm_state;
    logic       dev_clk, dev_data;

    int errors = 0;
    int checks = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(500),
        .FILTER_LEN    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .fsm_state  (fsm_state)
    );

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor counters, sampled on the falling edge.
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int acc_cnt = 0, acc_cyc = 0, done_cyc = 0;
    int busy_gap = 0;
    int clk_oe_cnt = 0, overlap_cnt = 0;
    logic rel_data_oe = 1'b0;
    logic prev_clk_oe = 1'b0;
    logic in_xfer = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) begin done_cnt++; done_cyc = cyc; end
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
        if (ps2_clk_oe) clk_oe_cnt++;
        if (ps2_clk_oe && ps2_data_oe) overlap_cnt++;
        if (prev_clk_oe && !ps2_clk_oe) rel_data_oe = ps2_data_oe;
        prev_clk_oe = ps2_clk_oe;
        if (in_xfer && !busy) busy_gap++;
        if (tx_done || tx_err || reset) in_xfer = 1'b0;
        if (tx_valid && tx_ready && !reset) begin
            acc_cnt++;
            acc_cyc = cyc;
            in_xfer = 1'b1;
        end
    end

    // Driver: present a byte and return on the negedge after acceptance.
    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device model: waits for the request, clocks `edges` periods, reads the
    // line on each rising edge. bits[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_run(input int edges, input bit ack, input int glitch_edge,
                           output logic [10:0] bits, output bit ok);
        int n;
        bits = '0;
        ok   = 1'b0;
        n    = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n < 300) begin
            ok = 1'b1;
            bits[0] = ps2_data_in;
            repeat (30) @(negedge clk);
            for (int k = 1; k <= edges; k++) begin
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                dev_clk = 1'b1;
                if (k <= 10) bits[k] = ps2_data_in;
                if (k == 10 && ack) dev_data = 1'b0;
                if (k == 11) dev_data = 1'b1;
                if (k == glitch_edge) begin
                    repeat (20) @(negedge clk);
                    dev_clk = 1'b0;
                    repeat (2) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (HALF - 22) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b need ready=1 busy=0", tx_ready, busy);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_oe: got clk_oe=%b data_oe=%b need 0 0", ps2_clk_oe, ps2_data_oe);
        end
        checks++;
        if (tx_done !== 1'b0 || tx_err !== 1'b0 || fsm_state !== 4'd0) begin
            errors++;
            $display("FAIL reset_pulses_state: got done=%b err=%b state=%0d need 0 0 0", tx_done, tx_err, fsm_state);
        end
    endtask

    // Full transfer with ACK; checks line bits against hand-computed values.
    task automatic test_send(input string name, input logic [7:0] b, input logic exp_par,
                             input int glitch_edge);
        logic [10:0] bits;
        bit ok;
        int d0, e0, g0;
        d0 = done_cnt; e0 = err_cnt; g0 = busy_gap;
        send(b);
        dev_run(11, 1'b1, glitch_edge, bits, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_request: no host request seen within bound", name);
        end
        checks++;
        if (bits[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: got %b need 0", name, bits[0]);
        end
        checks++;
        if (bits[8:1] !== b) begin
            errors++;
            $display("FAIL %s_byte: got %h need %h", name, bits[8:1], b);
        end
        checks++;
        if (bits[9] !== exp_par || bits[10] !== 1'b1) begin
            errors++;
            $display("FAIL %s_parity_stop: got %b %b need %b 1", name, bits[9], bits[10], exp_par);
        end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL %s_pulses: got done=%0d err=%0d need 1 0", name, done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (busy_gap != g0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got gaps=%0d ready=%b need 0 1", name, busy_gap - g0, tx_ready);
        end
    endtask

    task automatic test_inhibit;
        int c0, o0;
        c0 = clk_oe_cnt; o0 = overlap_cnt;
        test_send("inh00", 8'h00, 1'b1, 0);
        checks++;
        if (clk_oe_cnt - c0 != 20) begin
            errors++;
            $display("FAIL inhibit_len: got %0d cycles need 20", clk_oe_cnt - c0);
        end
        checks++;
        if (overlap_cnt != o0 || rel_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL inhibit_data_oe: got overlap=%0d at_release=%b need 0 1", overlap_cnt - o0, rel_data_oe);
        end
    endtask

    task automatic test_nack;
        logic [10:0] bits;
        bit ok;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(8'h12);
        dev_run(11, 1'b0, 0, bits, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || bits[8:1] !== 8'h12) begin
            errors++;
            $display("FAIL nack_byte: got ok=%b byte=%h need 1 12", ok, bits[8:1]);
        end
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL nack_pulses: got err=%0d done=%0d need 1 0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (tx_ready !== 1'b1 || fsm_state !== 4'd0) begin
            errors++;
            $display("FAIL nack_idle: got ready=%b state=%0d need 1 0", tx_ready, fsm_state);
        end
    endtask

    task automatic test_timeout;
        int n, m, d0;
        d0 = done_cnt;
        send(8'h5A);
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        m = 0;
        while (!tx_err && m < 800) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (m != 500) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles need 500", m);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_oe: got clk_oe=%b data_oe=%b need 0 0", ps2_clk_oe, ps2_data_oe);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_idle: got ready=%b done=%0d need 1 0", tx_ready, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits;
        bit ok;
        int d0, e0;
        send(8'hC3);
        dev_run(5, 1'b0, 0, bits, ok);
        checks++;
        if (ps2_data_oe !== 1'b1 || fsm_state !== 4'd3) begin
            errors++;
            $display("FAIL mid_pre_reset: got data_oe=%b state=%0d need 1 3", ps2_data_oe, fsm_state);
        end
        d0 = done_cnt; e0 = err_cnt;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got clk_oe=%b data_oe=%b ready=%b need 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL mid_no_pulse: got done=%0d err=%0d need 0 0", done_cnt - d0, err_cnt - e0);
        end
        test_send("after_reset_ff", 8'hFF, 1'b1, 0);
    endtask

    task automatic test_back_to_back;
        logic [10:0] b1, b2;
        bit ok1, ok2;
        int a0, d0;
        a0 = acc_cnt; d0 = done_cnt;
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        dev_run(11, 1'b1, 0, b1, ok1);
        checks++;
        if (acc_cyc - done_cyc != 1 || acc_cnt - a0 != 2) begin
            errors++;
            $display("FAIL b2b_reaccept: got gap=%0d accepts=%0d need 1 2", acc_cyc - done_cyc, acc_cnt - a0);
        end
        tx_valid = 1'b0;
        dev_run(11, 1'b1, 0, b2, ok2);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok1 || !ok2 || b1[9:1] !== 9'h001 || b2[9:1] !== 9'h001) begin
            errors++;
            $display("FAIL b2b_bits: got ok=%b%b b1=%h b2=%h need 11 001 001", ok1, ok2, b1[9:1], b2[9:1]);
        end
        checks++;
        if (acc_cnt - a0 != 2 || done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_counts: got accepts=%0d done=%0d need 2 2", acc_cnt - a0, done_cnt - d0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        @(negedge clk);
        test_reset;
        test_send("send_ed", 8'hED, 1'b1, 0);
        test_inhibit;
        test_nack;
        test_timeout;
        test_reset_mid;
        test_send("glitch_a5", 8'hA5, 1'b1, 4);
        test_back_to_back;
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL done_err_overlap: got %0d cycles need 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
